// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit-port arbiter.
package uart_tx_arbiter_pkg;

    // Arbiter FSM: idle/arbitrate, send source-ID header, stream payload.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    // Legal requester count range.
    localparam int NREQ_MIN = 2;
    localparam int NREQ_MAX = 16;

    // Width of an index into n requesters; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must be able to hold the value n.
    function automatic int cnt_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Rotate-priority encoder: first asserted request searching upward from
// ptr+1 with wrap. Purely combinational; the caller owns ptr and the grant.
module rr_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int cand;

    // Walk candidates ptr+1 .. ptr+N (mod N); the last served index is
    // therefore always the lowest priority.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART TX FIFO write port between NREQ packet sources.
// Round-robin grant held for a whole packet, optional source-ID header,
// watchdog release when the owner stops supplying bytes.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int              NREQ      = 4,
    parameter int              DBIT      = 8,
    parameter int              HEADER_EN = 1,
    parameter logic [DBIT-1:0] HDR_BASE  = 8'hA0,
    parameter int              TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DBIT-1:0] req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic                 abort_tick,
    output logic [DBIT-1:0]      w_data,
    output logic                 wr_uart,
    input  logic                 tx_full
);

    localparam int            IW      = idx_w(NREQ);
    localparam int            WW      = cnt_w(TIMEOUT);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [WW-1:0]   wdog_q, wdog_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;

    logic [DBIT-1:0] data_arr [NREQ];
    logic            valid_g;
    logic            last_g;
    logic [DBIT-1:0] data_g;
    logic [DBIT-1:0] hdr_byte;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DBIT +: DBIT];
    end

    rr_arbiter #(.N(NREQ)) u_rr (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Owner's lane, selected by the registered grant index.
    assign valid_g  = req_valid[gidx_q];
    assign last_g   = req_last[gidx_q];
    assign data_g   = data_arr[gidx_q];
    // Header wraps modulo 2**DBIT by construction of the DBIT-wide add.
    assign hdr_byte = HDR_BASE + DBIT'(gidx_q);

    assign grant = grant_q;
    assign busy  = (state_q != ST_IDLE);

    // Next-state, watchdog and the same-cycle write-port outputs.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        ptr_d      = ptr_q;
        wdog_d     = wdog_q;
        req_ready  = '0;
        wr_uart    = 1'b0;
        w_data     = '0;
        abort_tick = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Arbitrate only; nothing is written in this cycle, which is
                // what guarantees one idle cycle between packets.
                if (arb_any) begin
                    grant_d = arb_gnt;
                    gidx_d  = arb_idx;
                    wdog_d  = '0;
                    state_d = (HEADER_EN != 0) ? ST_HDR : ST_DATA;
                end
            end

            ST_HDR: begin
                w_data  = hdr_byte;
                wr_uart = ~tx_full;
                if (!tx_full) begin
                    state_d = ST_DATA;
                    wdog_d  = '0;
                end
            end

            ST_DATA: begin
                w_data            = data_g;
                req_ready[gidx_q] = ~tx_full;
                wr_uart           = valid_g & ~tx_full;
                if (valid_g && !tx_full) begin
                    wdog_d = '0;
                    if (last_g) begin
                        state_d = ST_IDLE;
                        ptr_d   = gidx_q;
                        grant_d = '0;
                    end
                end else if (!tx_full) begin
                    // Owner stalled while the FIFO had room: age the watchdog.
                    // A full FIFO is not the owner's fault, so it holds.
                    if (wdog_q == WD_LAST) begin
                        abort_tick = 1'b1;
                        state_d    = ST_IDLE;
                        ptr_d      = gidx_q;
                        grant_d    = '0;
                        wdog_d     = '0;
                    end else begin
                        wdog_d = wdog_q + WW'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; synchronous active-low reset drops any packet.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= IW'(NREQ - 1);
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios, then randomized packets
// checked against a packet-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int             NREQ     = 4;
    localparam int             DBIT     = 8;
    localparam int             TIMEOUT  = 8;
    localparam logic [DBIT-1:0] HDR_BASE = 8'hA0;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DBIT-1:0] req_data;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic                 abort_tick;
    logic [DBIT-1:0]      w_data;
    logic                 wr_uart;
    logic                 tx_full;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ(NREQ), .DBIT(DBIT), .HEADER_EN(1), .HDR_BASE(HDR_BASE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant), .busy(busy),
        .abort_tick(abort_tick), .w_data(w_data), .wr_uart(wr_uart), .tx_full(tx_full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i]             = v;
        req_data[i*DBIT +: DBIT] = d;
        req_last[i]              = l;
    endtask

    // Random-phase source storage and model.
    logic [7:0] src_data [NREQ][4][4];
    int         src_len  [NREQ][4];
    int         npk [NREQ];
    int         cur [NREQ];
    int         pos [NREQ];
    int         ord [$];

    initial begin
        logic [7:0] got [$];
        int         at  [$];
        logic [7:0] exp2 [10];
        int         n, pk, phase, owner, stall_run, rptr, left;
        logic       idle_due, stall;
        logic [7:0] hexp;

        reset = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_full = 1'b0;
        tick(); tick();

        // Reset state
        #1;
        chk("reset busy", busy, 0);
        chk("reset grant", grant, 0);
        chk("reset wr_uart", wr_uart, 0);
        chk("reset req_ready", req_ready, 0);
        chk("reset abort", abort_tick, 0);

        // 1: single packet A1,B2 from req0 with header
        reset = 1'b1;
        set_req(0, 1, 8'hA1, 0);
        #1; chk("t1 idle no write", wr_uart, 0); tick();
        #1; chk("t1 grant", grant, 4'b0001); chk("t1 hdr", w_data, 8'hA0); chk("t1 hdr wr", wr_uart, 1);
        chk("t1 hdr ready", req_ready, 0); tick();
        #1; chk("t1 b0", w_data, 8'hA1); chk("t1 b0 wr", wr_uart, 1); chk("t1 b0 ready", req_ready, 4'b0001); tick();
        set_req(0, 1, 8'hB2, 1);
        #1; chk("t1 b1", w_data, 8'hB2); chk("t1 b1 wr", wr_uart, 1); tick();
        req_valid = '0;
        #1; chk("t1 busy after", busy, 0); chk("t1 grant after", grant, 0); tick();

        // 2: round-robin, all four valid with 1-byte packets (ptr is 0 now)
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 8'(8'h10 + i), 1);
        exp2 = '{8'hA1, 8'h11, 8'hA2, 8'h12, 8'hA3, 8'h13, 8'hA0, 8'h10, 8'hA1, 8'h11};
        n = 0;
        while (got.size() < 10 && n < 40) begin
            #1;
            if (wr_uart) begin got.push_back(w_data); at.push_back(n); end
            tick(); n++;
            if (got.size() == 10) req_valid = '0;
        end
        chk("t2 writes", got.size(), 10);
        for (int k = 0; k < got.size() && k < 10; k++) chk($sformatf("t2 byte%0d", k), got[k], exp2[k]);
        for (int k = 2; k < at.size(); k += 2) chk($sformatf("t2 gap%0d", k), at[k] - at[k-1], 2);

        // 3: backpressure mid-packet from req2; owner stalls then FIFO full
        set_req(2, 1, 8'h31, 0);
        #1; tick();
        #1; chk("t3 hdr", w_data, 8'hA2); tick();
        #1; chk("t3 b0", w_data, 8'h31); chk("t3 b0 wr", wr_uart, 1); tick();
        req_valid[2] = 1'b0;
        for (int s = 0; s < 4; s++) begin
            #1; chk("t3 stall wr", wr_uart, 0); chk("t3 stall abort", abort_tick, 0); tick();
        end
        set_req(2, 1, 8'h32, 0); tx_full = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #1; chk("t3 full wr", wr_uart, 0); chk("t3 full ready", req_ready, 0);
            chk("t3 full abort", abort_tick, 0); chk("t3 full busy", busy, 1); tick();
        end
        tx_full = 1'b0;
        #1; chk("t3 b1", w_data, 8'h32); chk("t3 b1 wr", wr_uart, 1); tick();
        set_req(2, 1, 8'h33, 1);
        #1; chk("t3 b2", w_data, 8'h33); chk("t3 b2 wr", wr_uart, 1); tick();
        req_valid = '0;
        #1; chk("t3 busy after", busy, 0); tick();

        // 4: watchdog, req3 owns (ptr=2) and stops after one byte; req0 waits
        set_req(3, 1, 8'h41, 0); set_req(0, 1, 8'h50, 1);
        #1; tick();
        #1; chk("t4 grant", grant, 4'b1000); chk("t4 hdr", w_data, 8'hA3); tick();
        #1; chk("t4 b0", w_data, 8'h41); tick();
        req_valid[3] = 1'b0;
        for (int s = 1; s <= TIMEOUT; s++) begin
            #1; chk($sformatf("t4 abort s%0d", s), abort_tick, (s == TIMEOUT) ? 1 : 0);
            chk("t4 stall ready", req_ready, 4'b1000); chk("t4 stall wr", wr_uart, 0); tick();
        end
        #1; chk("t4 idle busy", busy, 0); chk("t4 idle grant", grant, 0); tick();
        #1; chk("t4 next grant", grant, 4'b0001); chk("t4 next hdr", w_data, 8'hA0); tick();
        #1; chk("t4 next b0", w_data, 8'h50); tick();
        req_valid = '0;
        #1; tick();

        // 5: reset mid-packet; req1 completes first so ptr=1, then req2 owns
        set_req(1, 1, 8'h61, 1);
        #1; tick();
        #1; tick();
        #1; chk("t5 req1 b0", w_data, 8'h61); tick();
        req_valid[1] = 1'b0; set_req(2, 1, 8'h71, 0);
        #1; tick();
        #1; chk("t5 req2 hdr", w_data, 8'hA2); tick();
        #1; chk("t5 req2 b0", w_data, 8'h71); tick();
        reset = 1'b0; req_valid = '0;
        #1; tick();
        reset = 1'b1; set_req(1, 1, 8'h81, 1); set_req(2, 1, 8'h72, 0);
        #1;
        chk("t5 post busy", busy, 0); chk("t5 post grant", grant, 0); chk("t5 post wr", wr_uart, 0);
        chk("t5 post ready", req_ready, 0); chk("t5 post abort", abort_tick, 0);
        tick();
        #1; chk("t5 grant lowest", grant, 4'b0010); chk("t5 hdr", w_data, 8'hA1); tick();
        #1; chk("t5 b0", w_data, 8'h81); tick();
        req_valid = '0;
        #1; tick();

        // Random phase: queued packets, random FIFO-full and owner stalls
        reset = 1'b0; tick(); reset = 1'b1;
        left = 0;
        for (int i = 0; i < NREQ; i++) begin
            npk[i] = $urandom_range(1, 4); cur[i] = 0; pos[i] = 0; left += npk[i];
            for (int p = 0; p < 4; p++) begin
                src_len[i][p] = $urandom_range(1, 4);
                for (int b = 0; b < 4; b++) src_data[i][p][b] = 8'($urandom_range(0, 255));
            end
        end
        // Every pending source stays valid between packets, so the serving
        // order is plain round-robin over sources with packets left.
        rptr = NREQ - 1;
        begin
            int rem [NREQ];
            for (int i = 0; i < NREQ; i++) rem[i] = npk[i];
            while (left > 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int c;
                    c = (rptr + k) % NREQ;
                    if (rem[c] > 0) begin
                        ord.push_back(c); rem[c]--; left--; rptr = c;
                        break;
                    end
                end
            end
        end

        pk = 0; phase = 0; stall_run = 0; idle_due = 1'b0; n = 0;
        while ((pk < ord.size() || idle_due) && n < 4000) begin
            owner = (pk < ord.size()) ? ord[pk] : -1;
            tx_full = ($urandom_range(0, 3) == 0);
            stall = 1'b0;
            if (phase == 1) begin
                stall = (stall_run < 3) && ($urandom_range(0, 3) == 0);
                stall_run = stall ? stall_run + 1 : 0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (cur[i] < npk[i])
                    set_req(i, !(stall && i == owner), src_data[i][cur[i]][pos[i]],
                            pos[i] == src_len[i][cur[i]] - 1);
                else
                    set_req(i, 0, 8'h00, 0);
            end
            #1;
            chk("rnd abort", abort_tick, 0);
            if (tx_full) chk("rnd full wr", wr_uart, 0);
            if (idle_due) begin
                chk("rnd gap busy", busy, 0); chk("rnd gap grant", grant, 0);
                idle_due = 1'b0;
            end
            if (phase == 1) begin
                chk("rnd grant", grant, 32'(1) << owner);
                chk("rnd ready", req_ready, tx_full ? 0 : (32'(1) << owner));
            end
            if (wr_uart && owner >= 0) begin
                if (phase == 0) begin
                    hexp = HDR_BASE + 8'(owner);
                    chk("rnd hdr", w_data, hexp);
                    chk("rnd hdr grant", grant, 32'(1) << owner);
                    phase = 1;
                end else begin
                    chk("rnd data", w_data, src_data[owner][cur[owner]][pos[owner]]);
                    pos[owner]++;
                    if (pos[owner] == src_len[owner][cur[owner]]) begin
                        pos[owner] = 0; cur[owner]++; pk++; phase = 0;
                        idle_due = 1'b1; stall_run = 0;
                    end
                end
            end
            tick(); n++;
        end
        chk("rnd packets done", pk, ord.size());
        req_valid = '0; tx_full = 1'b0;
        #1; chk("rnd final busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
